// File: rtl/alct_txd_frame_seq_pkg.sv
// Shared frame layout, FSM encoding and sync pattern constants for the ALCT transmit frame sequencer.
package alct_txd_frame_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        GAP  = 2'd2,
        SYNC = 2'd3
    } state_t;

    // din1st bit positions
    localparam int L1A    = 0;
    localparam int BX0    = 1;
    localparam int INJ    = 2;
    localparam int TRIG   = 3;
    localparam int CMD_LO = 4;
    // din2nd bit positions
    localparam int CMD_HI = 4;
    localparam int PAR    = 3;
    localparam int BXC    = 0;

    localparam logic [7:0] SYNC_EVEN = 8'h55;
    localparam logic [7:0] SYNC_ODD  = 8'hAA;

    typedef struct packed {
        logic trig;
        logic inj;
        logic bx0;
        logic l1a;
    } strobe_t;

endpackage

// File: rtl/alct_txd_frame_seq_parity.sv
// Odd-parity generator over 15 frame bits; output makes the total count of ones odd.
// Combinational, no latency, no backpressure. Only built when ALCT_TX_PARITY_EN is defined.
`ifdef ALCT_TX_PARITY_EN
module alct_txd_parity (
    input  logic [14:0] data,
    output logic        par
);
    assign par = ~(^data);
endmodule
`endif

// File: rtl/alct_txd_frame_seq.sv
// Per-crossing ALCT transmit frame builder: strobes, handshaked command, BX count, sync pattern.
// Latency: command on the wire 1 clock after its handshake edge; strobes ride in the same frame.
// Backpressure: registered cmd_ready, low for CMD_GAP+1 clocks per command and throughout SYNC.
// Optional odd parity on din2nd[3] when ALCT_TX_PARITY_EN is defined.
module alct_txd_frame_seq
    import alct_txd_frame_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CMD_GAP = 3
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             l1a,
    input  logic             bx0,
    input  logic             ext_inject,
    input  logic             ext_trig,
    input  logic [7:0]       cmd,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             sync_mode,
    output logic [WIDTH-1:0] din1st,
    output logic [WIDTH-1:0] din2nd,
    output logic             tx_en,
    output logic             sync_active
);

    if (WIDTH != 8) begin : g_width_chk
        $error("alct_txd_frame_seq: WIDTH must be 8");
    end
    if (CMD_GAP < 1 || CMD_GAP > 15) begin : g_gap_chk
        $error("alct_txd_frame_seq: CMD_GAP must be in 1..15");
    end

    localparam logic [3:0] GAP_LOAD = 4'(CMD_GAP);

    state_t     state;
    strobe_t    strb_q;
    logic [7:0] cmd_lat;
    logic [3:0] gap_cnt;
    logic [2:0] bxc;
    logic [2:0] bxc_nxt;
    logic       phase;
    logic [1:0] txen_sr;
    logic [7:0] cmd_frm;
    logic [7:0] frm1;
    logic [7:0] frm2;
    logic       par_bit;

    // The frame carrying bx0 is numbered 0; the counter runs free otherwise.
    assign bxc_nxt = strb_q.bx0 ? 3'd0 : bxc + 3'd1;
    assign cmd_frm = (state == CMD) ? cmd_lat : 8'h00;

    always_comb begin
        frm1               = '0;
        frm1[L1A]          = strb_q.l1a;
        frm1[BX0]          = strb_q.bx0;
        frm1[INJ]          = strb_q.inj;
        frm1[TRIG]         = strb_q.trig;
        frm1[CMD_LO +: 4]  = cmd_frm[3:0];
    end

`ifdef ALCT_TX_PARITY_EN
    logic [14:0] par_src;
    assign par_src = {frm1, cmd_frm[7:4], bxc_nxt};

    alct_txd_parity u_parity (
        .data (par_src),
        .par  (par_bit)
    );
`else
    assign par_bit = 1'b0;
`endif

    always_comb begin
        frm2               = '0;
        frm2[CMD_HI +: 4]  = cmd_frm[7:4];
        frm2[PAR]          = par_bit;
        frm2[BXC +: 3]     = bxc_nxt;
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state       <= IDLE;
            strb_q      <= '0;
            cmd_lat     <= 8'h00;
            gap_cnt     <= 4'd0;
            bxc         <= 3'd0;
            phase       <= 1'b0;
            txen_sr     <= 2'b00;
            tx_en       <= 1'b0;
            cmd_ready   <= 1'b0;
            sync_active <= 1'b0;
            din1st      <= '0;
            din2nd      <= '0;
        end else begin
            // Strobes seen while the sync pattern owns the wire are discarded.
            strb_q  <= (state == SYNC) ? strobe_t'(4'b0000)
                                       : strobe_t'({ext_trig, ext_inject, bx0, l1a});
            bxc     <= bxc_nxt;
            txen_sr <= {txen_sr[0], 1'b1};
            tx_en   <= txen_sr[1];

            if (state == SYNC) begin
                din1st      <= phase ? SYNC_ODD : SYNC_EVEN;
                din2nd      <= phase ? SYNC_ODD : SYNC_EVEN;
                phase       <= ~phase;
                sync_active <= 1'b1;
            end else begin
                din1st      <= frm1;
                din2nd      <= frm2;
                phase       <= 1'b0;
                sync_active <= 1'b0;
            end

            cmd_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_lat <= cmd;
                        state   <= CMD;
                    end else if (sync_mode) begin
                        state <= SYNC;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                CMD: begin
                    state   <= GAP;
                    gap_cnt <= GAP_LOAD;
                end
                GAP: begin
                    if (gap_cnt == 4'd1) begin
                        state     <= IDLE;
                        gap_cnt   <= 4'd0;
                        cmd_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                SYNC: begin
                    if (!sync_mode) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alct_txd_frame_seq.sv
// Bench for alct_txd_frame_seq: directed table, corner sequences and random traffic
// checked against an edge-indexed reference model of the frame rules.
module tb_alct_txd_frame_seq;

    localparam int CMD_GAP = 3;

    logic       clock = 1'b0;
    logic       clr_n;
    logic       l1a, bx0, ext_inject, ext_trig;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       sync_mode;
    logic [7:0] din1st, din2nd;
    logic       tx_en, sync_active;

    alct_txd_frame_seq #(.WIDTH(8), .CMD_GAP(CMD_GAP)) dut (
        .clock       (clock),
        .clr_n       (clr_n),
        .l1a         (l1a),
        .bx0         (bx0),
        .ext_inject  (ext_inject),
        .ext_trig    (ext_trig),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .sync_mode   (sync_mode),
        .din1st      (din1st),
        .din2nd      (din2nd),
        .tx_en       (tx_en),
        .sync_active (sync_active)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: everything is keyed on the edge number n since reset release.
    int         n;
    int         hs_edge;    // edge of the last accepted command
    int         anchor;     // edge whose frame shows bxc = 0
    int         s_start;    // edge at which sync was entered
    logic       m_sync, m_idle, m_rdy;
    logic [7:0] m_cmd;
    logic       p_l1a, p_bx0, p_inj, p_trig;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s edge=%0d got=%h want=%h", name, n, act, exp);
    endtask

    task automatic model_reset();
        n = 0; hs_edge = -1000; anchor = 0; s_start = 0;
        m_sync = 1'b0; m_idle = 1'b1; m_rdy = 1'b0; m_cmd = 8'h00;
        p_l1a = 1'b0; p_bx0 = 1'b0; p_inj = 1'b0; p_trig = 1'b0;
    endtask

    task automatic zero_inputs();
        l1a = 0; bx0 = 0; ext_inject = 0; ext_trig = 0;
        cmd = 8'h00; cmd_valid = 0; sync_mode = 0;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        zero_inputs();
        #1;
        chk("rst_din1st", din1st, 8'h00);
        chk("rst_din2nd", din2nd, 8'h00);
        chk("rst_ready", {7'd0, cmd_ready}, 8'h00);
        chk("rst_txen", {7'd0, tx_en}, 8'h00);
        chk("rst_sync", {7'd0, sync_active}, 8'h00);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_hold_din2nd", din2nd, 8'h00);
        model_reset();
        clr_n = 1'b1;
    endtask

    // Advance one clock with the currently driven inputs and check all outputs.
    task automatic tick();
        logic [7:0] e1, e2, c;
        logic       esa, hs_now, was_sync;
        int         b;
        n++;
        was_sync = m_sync;
        hs_now   = cmd_valid && m_rdy;
        if (m_sync) begin
            e1  = ((n - s_start) % 2 == 1) ? 8'h55 : 8'hAA;
            e2  = e1;
            esa = 1'b1;
        end else begin
            c   = (hs_edge == n - 1) ? m_cmd : 8'h00;
            b   = (n - anchor) % 8;
            e1  = {c[3:0], p_trig, p_inj, p_bx0, p_l1a};
            e2  = {c[7:4], 1'b0, 3'(b)};
`ifdef ALCT_TX_PARITY_EN
            e2[3] = ~(^{e1, e2[7:4], e2[2:0]});
`endif
            esa = 1'b0;
        end
        if (!was_sync && bx0) anchor = n + 1;
        p_l1a  = !was_sync && l1a;
        p_bx0  = !was_sync && bx0;
        p_inj  = !was_sync && ext_inject;
        p_trig = !was_sync && ext_trig;
        if (hs_now) begin
            hs_edge = n;
            m_cmd   = cmd;
        end
        if (was_sync) begin
            if (!sync_mode) m_sync = 1'b0;
        end else if (m_idle && !hs_now && sync_mode) begin
            m_sync  = 1'b1;
            s_start = n;
        end
        m_idle = !m_sync && (n >= hs_edge + CMD_GAP + 1);
        m_rdy  = m_idle;

        @(posedge clock);
        #1;
        chk("din1st", din1st, e1);
        chk("din2nd", din2nd, e2);
        chk("cmd_ready", {7'd0, cmd_ready}, {7'd0, m_rdy});
        chk("sync_active", {7'd0, sync_active}, {7'd0, esa});
        chk("tx_en", {7'd0, tx_en}, {7'd0, logic'(n >= 3)});
    endtask

    typedef struct packed {
        logic       l1a;
        logic       bx0;
        logic       cv;
        logic [7:0] cmd;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       rdy;
        logic       txen;
    } vec_t;

    vec_t tbl [13];

`ifdef ALCT_TX_PARITY_EN
    localparam logic [7:0] D2_MASK = 8'hF7;
`else
    localparam logic [7:0] D2_MASK = 8'hFF;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // l1a bx0 cv cmd    din1st din2nd rdy txen  (after edges 1..13 from release)
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'h00, 8'h04, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h50, 8'hA5, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h06, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h07, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h3C, 8'h00, 8'h01, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hC3, 8'h30, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03, 1'b1, 1'b1};

        model_reset();
        do_reset();

        for (int i = 0; i < 13; i++) begin
            l1a = tbl[i].l1a; bx0 = tbl[i].bx0;
            cmd_valid = tbl[i].cv; cmd = tbl[i].cmd;
            tick();
            chk("tbl_din1st", din1st, tbl[i].d1);
            chk("tbl_din2nd", din2nd & D2_MASK, tbl[i].d2 & D2_MASK);
            chk("tbl_ready", {7'd0, cmd_ready}, {7'd0, tbl[i].rdy});
            chk("tbl_txen", {7'd0, tx_en}, {7'd0, tbl[i].txen});
        end
        zero_inputs();

        // Sync held 6 clocks, strobes injected inside and on the exit clock.
        for (int k = 1; k <= 8; k++) begin
            sync_mode = (k <= 6);
            l1a = (k == 3 || k == 7);
            tick();
            if (k >= 2 && k <= 7) begin
                chk("sync_pat", din1st, (k % 2 == 0) ? 8'h55 : 8'hAA);
                chk("sync_pat2", din2nd, (k % 2 == 0) ? 8'h55 : 8'hAA);
                chk("sync_act", {7'd0, sync_active}, 8'h01);
            end
            if (k == 8) begin
                chk("sync_exit_act", {7'd0, sync_active}, 8'h00);
                chk("sync_drop_l1a", din1st, 8'h00);
            end
        end
        zero_inputs();

        // Command and sync requested together: command wins, sync follows the gap.
        for (int k = 1; k <= 8; k++) begin
            cmd_valid = (k == 1);
            cmd = 8'h81;
            sync_mode = 1'b1;
            tick();
            if (k == 2) begin
                chk("cs_cmd_lo", din1st, 8'h10);
                chk("cs_cmd_hi", din2nd & 8'hF0, 8'h80);
            end
            if (k >= 2 && k <= 6) chk("cs_no_sync", {7'd0, sync_active}, 8'h00);
            if (k == 7) begin
                chk("cs_sync", {7'd0, sync_active}, 8'h01);
                chk("cs_sync_pat", din1st, 8'h55);
            end
        end
        zero_inputs();
        tick();
        tick();

        // Asynchronous reset in the middle of the gap.
        cmd_valid = 1'b1; cmd = 8'hFF;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("gap_cmd_seen", din1st & 8'hF0, 8'hF0);
        tick();
        #2;
        do_reset();
        tick();
        chk("post_rst_ready", {7'd0, cmd_ready}, 8'h01);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            l1a        = ($urandom_range(0, 4) == 0);
            bx0        = ($urandom_range(0, 7) == 0);
            ext_inject = ($urandom_range(0, 5) == 0);
            ext_trig   = ($urandom_range(0, 5) == 0);
            cmd_valid  = ($urandom_range(0, 9) < 4);
            cmd        = 8'($urandom);
            if ($urandom_range(0, 9) == 0) sync_mode = ~sync_mode;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
